// File: rtl/fcvt_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// fcvt_arbiter_ctrl
//
// Arbitrates two requesters (bit 0 = integer pipe, bit 1 = FP pipe) onto a
// single shared floating-point converter. One operation is in flight at a
// time: a granted request is latched, its operands are held on the cvt_*
// outputs for LATENCY cycles, the converter result is captured, and the
// result is presented on resp_* until the consumer takes it.
//
// Parameters
//   LATENCY  cycles the converter operands are held before capture (1..15)
//   OPW      width of the operation code
//
// Ports
//   clk, reset         block clock; asynchronous active-high reset
//   req_valid[1:0]     per-requester request valid
//   req_ready[1:0]     per-requester accept strobe (one-hot or zero)
//   req_op             {op1, op0}, OPW bits each
//   req_rs1, req_rs2   {rs_1, rs_0}, 32 bits each
//   req_rm             {rm1, rm0}, 3 bits each; 3'b111 selects frm
//   frm                dynamic rounding mode from fcsr
//   flush              pipeline kill; forces IDLE and drops any response
//   cvt_op/rs1/rs2/rm  registered operands driven to the shared converter
//   cvt_result         combinational converter result
//   resp_valid/ready   response handshake
//   resp_data          captured result (zero when the rounding mode is illegal)
//   resp_id            requester that originated the response
//   resp_err           illegal rounding mode flag
// ---------------------------------------------------------------------------
module fcvt_arbiter_ctrl #(
  parameter int LATENCY = 2,
  parameter int OPW     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*OPW-1:0] req_op,
  input  logic [63:0]      req_rs1,
  input  logic [63:0]      req_rs2,
  input  logic [5:0]       req_rm,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic [OPW-1:0]   cvt_op,
  output logic [31:0]      cvt_rs1,
  output logic [31:0]      cvt_rs2,
  output logic [2:0]       cvt_rm,
  input  logic [31:0]      cvt_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic             resp_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic           last_grant;
  logic [3:0]     cnt;
  logic           id_q;
  logic           err_q;

  logic [1:0]     grant;
  logic           accept;
  logic           sel;
  logic [OPW-1:0] sel_op;
  logic [31:0]    sel_rs1;
  logic [31:0]    sel_rs2;
  logic [2:0]     sel_rm_raw;
  logic [2:0]     sel_rm;

  // The instruction field 3'b111 means "use the dynamic mode from fcsr".
  function automatic logic [2:0] resolve_rm(input logic [2:0] rm_field,
                                            input logic [2:0] dyn_rm);
    return (rm_field == 3'b111) ? dyn_rm : rm_field;
  endfunction

  // Encodings 5 and 6 are reserved; 7 can only arrive here through frm,
  // which is itself illegal as a dynamic mode.
  function automatic logic rm_illegal(input logic [2:0] rm);
    return (rm == 3'd5) || (rm == 3'd6) || (rm == 3'd7);
  endfunction

  // Round-robin: a lone requester always wins; under contention the one
  // that did not win last time is chosen.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign sel        = grant[1];
  assign sel_op     = sel ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  assign sel_rs1    = sel ? req_rs1[63:32]      : req_rs1[31:0];
  assign sel_rs2    = sel ? req_rs2[63:32]      : req_rs2[31:0];
  assign sel_rm_raw = sel ? req_rm[5:3]         : req_rm[2:0];
  assign sel_rm     = resolve_rm(sel_rm_raw, frm);

  // Next state and accept strobe. reset gates req_ready so the strobe reads
  // zero for the whole time reset is held, not just after the next edge.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && !reset) begin
          req_ready = grant;
          accept    = |grant;
          if (|grant) state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush wins over acceptance and over response completion.
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- acceptance: latch operands, resolved rm and originator ----
  // ---- execute: count down, then capture the converter result ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cvt_op     <= '0;
      cvt_rs1    <= '0;
      cvt_rs2    <= '0;
      cvt_rm     <= '0;
      err_q      <= 1'b0;
      id_q       <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cvt_op     <= sel_op;
        cvt_rs1    <= sel_rs1;
        cvt_rs2    <= sel_rs2;
        cvt_rm     <= sel_rm;
        err_q      <= rm_illegal(sel_rm);
        id_q       <= sel;
        last_grant <= sel;
        cnt        <= CNT_INIT;
      end

      if (state == EXEC && !flush) begin
        if (cnt == 4'd0) begin
          resp_valid <= 1'b1;
          resp_data  <= err_q ? 32'd0 : cvt_result;
          resp_id    <= id_q;
          resp_err   <= err_q;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end

      // ---- response: hold until taken, or drop on flush ----
      if (state == RESP && (flush || resp_ready)) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (reset)
    (req_ready != 2'b00) |-> (state == IDLE));

  a_cvt_hold: assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |=> $stable({cvt_op, cvt_rs1, cvt_rs2, cvt_rm}));
`endif

endmodule

// File: tb/tb_fcvt_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for fcvt_arbiter_ctrl. A stub converter computes a simple mixing
// function of the cvt_* operands. A transaction-level model predicts the
// DUT outputs every cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_fcvt_arbiter_ctrl;

  localparam int LAT = 2;
  localparam int OPW = 6;
  localparam logic [OPW-1:0] OP_FCVTW = 6'h18;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_op;
  logic [63:0]      req_rs1;
  logic [63:0]      req_rs2;
  logic [5:0]       req_rm;
  logic [2:0]       frm;
  logic             flush;
  logic [OPW-1:0]   cvt_op;
  logic [31:0]      cvt_rs1;
  logic [31:0]      cvt_rs2;
  logic [2:0]       cvt_rm;
  logic [31:0]      cvt_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_id;
  logic             resp_err;

  logic [OPW-1:0]   p_op  [2];
  logic [31:0]      p_rs1 [2];
  logic [31:0]      p_rs2 [2];
  logic [2:0]       p_rm  [2];

  assign req_op  = {p_op[1],  p_op[0]};
  assign req_rs1 = {p_rs1[1], p_rs1[0]};
  assign req_rs2 = {p_rs2[1], p_rs2[0]};
  assign req_rm  = {p_rm[1],  p_rm[0]};

  always #5 clk = ~clk;

  fcvt_arbiter_ctrl #(.LATENCY(LAT), .OPW(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rm     (req_rm),
    .frm        (frm),
    .flush      (flush),
    .cvt_op     (cvt_op),
    .cvt_rs1    (cvt_rs1),
    .cvt_rs2    (cvt_rs2),
    .cvt_rm     (cvt_rm),
    .cvt_result (cvt_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  // Stub converter: any result that depends on every operand field will do.
  function automatic logic [31:0] conv(input logic [OPW-1:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [2:0] rm);
    return (a ^ {b[15:0], b[31:16]}) + 32'(op) + 32'(rm);
  endfunction

  assign cvt_result = conv(cvt_op, cvt_rs1, cvt_rs2, cvt_rm);

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------
  // Transaction model: one operation at a time, response appears
  // LAT edges after the accepting edge, held until taken.
  // ------------------------------------------------------------------
  bit             m_inflight = 1'b0;
  bit             m_rv       = 1'b0;
  bit             m_last     = 1'b1;
  int             m_k        = 0;
  int             m_t        = 0;
  logic [OPW-1:0] m_op       = '0;
  logic [31:0]    m_rs1      = '0;
  logic [31:0]    m_rs2      = '0;
  logic [2:0]     m_rm       = '0;
  logic [31:0]    m_data     = '0;
  bit             m_id       = 1'b0;
  bit             m_err      = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic [1:0] exp_ready;
    logic [2:0] rr;
    int         g;
    m_k++;
    if (reset) begin
      chk("m_rst_req_ready",  req_ready,  0);
      chk("m_rst_resp_valid", resp_valid, 0);
      chk("m_rst_resp_data",  resp_data,  0);
      chk("m_rst_cvt_op",     cvt_op,     0);
      chk("m_rst_cvt_rs1",    cvt_rs1,    0);
      chk("m_rst_cvt_rm",     cvt_rm,     0);
      m_inflight = 1'b0;
      m_rv       = 1'b0;
      m_last     = 1'b1;
      m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rm = '0;
    end else begin
      exp_ready = 2'b00;
      g = 0;
      if (!m_inflight && !m_rv && !flush && req_valid != 2'b00) begin
        if (req_valid == 2'b11) g = m_last ? 0 : 1;
        else                    g = req_valid[1] ? 1 : 0;
        exp_ready = 2'b01 << g;
      end
      chk("m_req_ready",  req_ready,  exp_ready);
      chk("m_resp_valid", resp_valid, m_rv);
      chk("m_cvt_op",     cvt_op,     m_op);
      chk("m_cvt_rs1",    cvt_rs1,    m_rs1);
      chk("m_cvt_rs2",    cvt_rs2,    m_rs2);
      chk("m_cvt_rm",     cvt_rm,     m_rm);
      if (m_rv) begin
        chk("m_resp_data", resp_data, m_data);
        chk("m_resp_id",   resp_id,   m_id);
        chk("m_resp_err",  resp_err,  m_err);
      end

      if (flush) begin
        m_inflight = 1'b0;
        m_rv       = 1'b0;
      end else if (m_rv) begin
        if (resp_ready) m_rv = 1'b0;
      end else if (m_inflight) begin
        if (m_k + 1 == m_t) begin
          m_rv       = 1'b1;
          m_inflight = 1'b0;
        end
      end else if (exp_ready != 2'b00) begin
        rr         = (p_rm[g] == 3'b111) ? frm : p_rm[g];
        m_op       = p_op[g];
        m_rs1      = p_rs1[g];
        m_rs2      = p_rs2[g];
        m_rm       = rr;
        m_err      = (rr >= 3'd5);
        m_data     = m_err ? 32'd0 : conv(p_op[g], p_rs1[g], p_rs2[g], rr);
        m_id       = (g == 1);
        m_last     = (g == 1);
        m_inflight = 1'b1;
        m_t        = m_k + 1 + LAT;
      end
    end
  end

  // ------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 unit after a rising edge; literal
  // checks happen 1 unit after a falling edge.
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] rm);
    p_op[i] = op; p_rs1[i] = a; p_rs2[i] = b; p_rm[i] = rm;
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    look();
    while (!resp_valid && n < 20) begin
      tick();
      look();
      n++;
    end
    chk(name, resp_valid, 1);
  endtask

  task automatic handshake();
    tick();
    resp_ready = 1'b1;
    look();
    tick();
    resp_ready = 1'b0;
  endtask

  logic [31:0] hold_d;
  logic        hold_id;

  initial begin
    req_valid = 2'b00; frm = 3'd0; flush = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) set_req(i, '0, '0, '0, '0);
    repeat (3) tick();
    reset = 1'b0;

    // Contention after reset: requester 0 first, then round-robin.
    set_req(0, 6'h05, 32'h12345678, 32'h00000001, 3'd0);
    set_req(1, 6'h0a, 32'hdeadbeef, 32'h00ff00ff, 3'd1);
    frm = 3'd2;
    req_valid = 2'b11;
    look();
    chk("first_grant", req_ready, 2'b01);
    tick();
    set_req(0, 6'h03, 32'h000000ff, 32'h0, 3'd0);
    look();
    chk("exec_no_ready", req_ready, 2'b00);
    chk("lat_cycle1", resp_valid, 0);
    tick(); look();
    chk("lat_cycle2", resp_valid, 0);
    tick(); look();
    chk("lat_cycle3", resp_valid, 1);
    chk("resp0_id", resp_id, 0);
    chk("resp0_data", resp_data, 32'h1235567d);
    chk("resp0_err", resp_err, 0);
    handshake();
    look();
    chk("rr_second_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    wait_resp("resp1_valid");
    chk("resp1_id", resp_id, 1);
    chk("resp1_data", resp_data, 32'hde52be1b);
    handshake();
    look();
    chk("rr_back_to_0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_resp("resp2_valid");
    chk("resp2_data", resp_data, 32'h00000102);
    handshake();

    // Dynamic rounding mode.
    set_req(0, OP_FCVTW, 32'h40490fdb, 32'h0, 3'b111);
    frm = 3'b010;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    look();
    chk("dyn_rm_cvt_rm", cvt_rm, 3'b010);
    chk("dyn_rm_cvt_op", cvt_op, OP_FCVTW);
    wait_resp("dyn_rm_resp");
    handshake();

    // Illegal rounding modes: static 5 and dynamic 7.
    set_req(0, 6'h11, 32'h3f800000, 32'h0, 3'b101);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp("rm5_resp");
    chk("rm5_err", resp_err, 1);
    chk("rm5_data", resp_data, 32'h0);
    handshake();
    set_req(1, 6'h11, 32'h3f800000, 32'h0, 3'b111);
    frm = 3'b111;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    frm = 3'b010;
    wait_resp("frm7_resp");
    chk("frm7_err", resp_err, 1);
    chk("frm7_data", resp_data, 32'h0);
    handshake();

    // Back-pressure: response held for 5 cycles with a request pending.
    set_req(1, 6'h21, 32'hcafe0000, 32'h0000beef, 3'd3);
    set_req(0, 6'h01, 32'h00000001, 32'h00000002, 3'd0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b01;
    wait_resp("hold_resp");
    hold_d  = resp_data;
    hold_id = resp_id;
    chk("hold_id", hold_id, 1);
    chk("hold_data", hold_d, 32'h74110024);
    for (int i = 0; i < 5; i++) begin
      tick(); look();
      chk("hold_valid", resp_valid, 1);
      chk("hold_data_stable", resp_data, hold_d);
      chk("hold_id_stable", resp_id, hold_id);
      chk("hold_no_ready", req_ready, 2'b00);
    end
    handshake();

    // Flush in EXEC: requester 0 accepted at the next edge, then killed.
    tick();
    flush = 1'b1;
    req_valid = 2'b10;
    set_req(1, 6'h07, 32'h00000055, 32'h00000066, 3'd4);
    look();
    chk("flush_exec_no_ready", req_ready, 2'b00);
    tick();
    flush = 1'b0;
    look();
    chk("flush_no_resp", resp_valid, 0);
    chk("flush_then_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_resp("after_flush_resp");
    chk("after_flush_id", resp_id, 1);
    chk("after_flush_data", resp_data, 32'h00660060);
    handshake();

    // Flush beats acceptance in IDLE.
    req_valid = 2'b01;
    flush = 1'b1;
    look();
    chk("flush_idle_no_ready", req_ready, 2'b00);
    tick();
    flush = 1'b0;
    look();
    chk("flush_idle_release", req_ready, 2'b01);

    // Flush in RESP drops the response and keeps last_grant (= 0).
    tick();
    req_valid = 2'b00;
    wait_resp("pre_flush_resp");
    tick();
    flush = 1'b1;
    resp_ready = 1'b1;
    look();
    tick();
    flush = 1'b0;
    resp_ready = 1'b0;
    req_valid = 2'b11;
    look();
    chk("flush_resp_drop", resp_valid, 0);
    chk("flush_keeps_last", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_resp("post_flush_resp");
    handshake();

    // Asynchronous reset in RESP.
    set_req(1, 6'h2a, 32'h0badf00d, 32'h12345678, 3'd0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_resp("pre_reset_resp");
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_resp_id", resp_id, 0);
    chk("arst_resp_err", resp_err, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_cvt_op", cvt_op, 0);
    chk("arst_cvt_rs1", cvt_rs1, 0);
    chk("arst_cvt_rs2", cvt_rs2, 0);
    chk("arst_cvt_rm", cvt_rm, 0);
    tick(); tick();
    reset = 1'b0;
    look();
    chk("post_reset_grant", req_ready, 2'b01);
    chk("post_reset_no_resp", resp_valid, 0);
    tick();
    req_valid = 2'b00;
    wait_resp("post_reset_resp");
    chk("post_reset_id", resp_id, 0);
    handshake();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d of %0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
